// File: rtl/serial_comparator.sv
// serial_comparator
// Bit-serial magnitude comparator. On an accepted Start the two operands are
// captured and walked MSB-first, one bit per clock, until the first differing
// bit or the LSB. The result is then presented as one-hot GT/EQ/LT together
// with a one-cycle Done strobe. GT/EQ/LT feed the D inputs of the downstream
// result flops, and Done drives their enables.
//
// Handshake: Start is a request with no acknowledge. It is accepted only when
// the block is idle, or in the Done cycle for back-to-back work. A Start
// raised while Busy is high is dropped. A and B matter only in the cycle where
// Start is accepted. Done is high for exactly one cycle per completed compare.
// The flags are valid from that cycle and stay valid until the next accepted
// Start or RST.
//
// dbg_state exposes the FSM state so that external checkers can observe it:
// 0 = IDLE, 1 = CMP, 2 = DONE.

module serial_comparator #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             GT,
    output logic             EQ,
    output logic             LT,
    output logic [1:0]       dbg_state
);

    // The counter only needs to reach WIDTH-1. It never wraps.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CW-1:0]    cnt;
    logic             gt_q;
    logic             eq_q;
    logic             lt_q;

    logic [WIDTH-1:0] sa_nxt;
    logic [WIDTH-1:0] sb_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic             gt_nxt;
    logic             eq_nxt;
    logic             lt_nxt;

    // These are the bits under examination. They are always the current MSBs
    // of the shift registers.
    logic bit_a;
    logic bit_b;
    logic is_last;
    logic accept;

    assign bit_a   = sa[WIDTH-1];
    assign bit_b   = sb[WIDTH-1];
    assign is_last = (cnt == CNT_LAST);
    // A new operation may start from IDLE, or from DONE for back-to-back work.
    assign accept  = Start && ((state == S_IDLE) || (state == S_DONE));

    // State register. A synchronous reset overrides every other input.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. CMP exits on the first differing bit, or after the
    // WIDTH-th evaluation.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    state_nxt = S_CMP;
                end
            end
            S_CMP: begin
                if ((bit_a != bit_b) || is_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (Start) begin
                    state_nxt = S_CMP;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath and result decode. This covers loading, shifting, counting and
    // resolving the flags.
    always_comb begin
        sa_nxt  = sa;
        sb_nxt  = sb;
        cnt_nxt = cnt;
        gt_nxt  = gt_q;
        eq_nxt  = eq_q;
        lt_nxt  = lt_q;
        if (accept) begin
            sa_nxt  = A;
            sb_nxt  = B;
            cnt_nxt = '0;
            gt_nxt  = 1'b0;
            eq_nxt  = 1'b0;
            lt_nxt  = 1'b0;
        end else if (state == S_CMP) begin
            if (bit_a != bit_b) begin
                // For a two's-complement sign bit, a set bit means the smaller
                // value, so the sense is inverted.
                if (SIGNED && (cnt == '0)) begin
                    gt_nxt = bit_b;
                    lt_nxt = bit_a;
                end else begin
                    gt_nxt = bit_a;
                    lt_nxt = bit_b;
                end
                eq_nxt = 1'b0;
            end else if (is_last) begin
                eq_nxt = 1'b1;
            end else begin
                sa_nxt  = {sa[WIDTH-2:0], 1'b0};
                sb_nxt  = {sb[WIDTH-2:0], 1'b0};
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    // Datapath and result registers. Busy and Done are registered decodes of
    // the state being entered, so they line up with the state itself.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sa   <= '0;
            sb   <= '0;
            cnt  <= '0;
            gt_q <= 1'b0;
            eq_q <= 1'b0;
            lt_q <= 1'b0;
            Busy <= 1'b0;
            Done <= 1'b0;
        end else begin
            sa   <= sa_nxt;
            sb   <= sb_nxt;
            cnt  <= cnt_nxt;
            gt_q <= gt_nxt;
            eq_q <= eq_nxt;
            lt_q <= lt_nxt;
            Busy <= (state_nxt == S_CMP);
            Done <= (state_nxt == S_DONE);
        end
    end

    assign GT        = gt_q;
    assign EQ        = eq_q;
    assign LT        = lt_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_serial_comparator.sv
// Directed bench for serial_comparator. It runs an unsigned and a signed
// instance side by side on the same stimulus. The expected values are worked
// out by hand for each vector.

module tb_serial_comparator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;

    logic       busy_u, done_u, gt_u, eq_u, lt_u;
    logic       busy_s, done_s, gt_s, eq_s, lt_s;
    logic [1:0] st_u, st_s;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [5:0] exp_q[$];

    serial_comparator #(.WIDTH(8), .SIGNED(1'b0)) u_uns (
        .CLK(clk), .RST(rst), .Start(start), .A(a), .B(b),
        .Busy(busy_u), .Done(done_u), .GT(gt_u), .EQ(eq_u), .LT(lt_u),
        .dbg_state(st_u)
    );

    serial_comparator #(.WIDTH(8), .SIGNED(1'b1)) u_sgn (
        .CLK(clk), .RST(rst), .Start(start), .A(a), .B(b),
        .Busy(busy_s), .Done(done_s), .GT(gt_s), .EQ(eq_s), .LT(lt_s),
        .dbg_state(st_s)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Advance one active edge, then settle away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver: issue one compare and wait (bounded) for Done on the unsigned
    // instance. Then score latency, Busy length and flags of both instances.
    task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                          input int exp_lat, input logic [2:0] exp_u, input logic [2:0] exp_s);
        int lat = 0;
        int busy_n = 0;
        logic [5:0] e;
        exp_q.push_back({exp_u, exp_s});
        a = va; b = vb; start = 1'b1;
        step();
        start = 1'b0;
        if (busy_u) busy_n++;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (busy_u) busy_n++;
            if (done_u) begin
                lat = k;
                break;
            end
        end
        e = exp_q.pop_front();
        chk({tag, "_lat"}, 8'(lat), 8'(exp_lat));
        chk({tag, "_busy"}, 8'(busy_n), 8'(exp_lat));
        chk({tag, "_flags_u"}, {5'd0, gt_u, eq_u, lt_u}, {5'd0, e[5:3]});
        chk({tag, "_flags_s"}, {5'd0, gt_s, eq_s, lt_s}, {5'd0, e[2:0]});
        chk({tag, "_done_s"}, {7'd0, done_s}, 8'd1);
        step();
        chk({tag, "_done_end"}, {7'd0, done_u}, 8'd0);
    endtask

    initial begin
        int seen;
        int lat;
        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
        step();
        step();
        chk("reset_u", {3'd0, busy_u, done_u, gt_u, eq_u, lt_u}, 8'h00);
        chk("reset_s", {3'd0, busy_s, done_s, gt_s, eq_s, lt_s}, 8'h00);
        rst = 1'b0;
        step();

        // RST mid-compare. Start raised together with RST must be ignored.
        a = 8'h3C; b = 8'h3C; start = 1'b1;
        step();                                   // E0
        start = 1'b0;
        chk("rst_mid_busy0", {7'd0, busy_u}, 8'd1);
        step();                                   // E1
        step();                                   // E2
        rst = 1'b1; start = 1'b1;
        step();                                   // E3
        rst = 1'b0; start = 1'b0;
        chk("rst_mid_outs", {3'd0, busy_u, done_u, gt_u, eq_u, lt_u}, 8'h00);
        chk("rst_mid_state", {6'd0, st_u}, 8'd0);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (done_u || busy_u) seen++;
        end
        chk("rst_no_done", 8'(seen), 8'd0);

        // MSB differs: A5 vs 35. Unsigned gives GT, signed gives LT (-91 < 53).
        a = 8'hA5; b = 8'h35; start = 1'b1;
        step();                                   // E0
        start = 1'b0;
        chk("msb_busy", {7'd0, busy_u}, 8'd1);
        step();                                   // E1
        chk("msb_u", {3'd0, busy_u, done_u, gt_u, eq_u, lt_u}, 8'b0000_1100);
        chk("msb_s", {3'd0, busy_s, done_s, gt_s, eq_s, lt_s}, 8'b0000_1001);
        step();                                   // E2
        chk("msb_done_off", {7'd0, done_u}, 8'd0);
        step(); step(); step();                   // E5
        chk("msb_hold", {3'd0, busy_u, done_u, gt_u, eq_u, lt_u}, 8'b0000_0100);

        // FE vs FD: first difference at offset 6. Both modes give GT (-2 > -3).
        run_op("fe_fd", 8'hFE, 8'hFD, 7, 3'b100, 3'b100);
        // Equal operands: worst-case latency.
        run_op("eq_3c", 8'h3C, 8'h3C, 8, 3'b010, 3'b010);
        // LSB differs.
        run_op("lsb_40_41", 8'h40, 8'h41, 8, 3'b001, 3'b001);
        // Sign bit only, signed view: 80 (-128) < 00.
        run_op("sign_80_00", 8'h80, 8'h00, 1, 3'b100, 3'b001);

        // Start while busy is dropped.
        a = 8'h00; b = 8'h01; start = 1'b1;
        step();                                   // E0
        start = 1'b0;
        step();                                   // E1
        step();                                   // E2
        a = 8'hFF; b = 8'h00; start = 1'b1;
        step();                                   // E3
        start = 1'b0;
        chk("busy_ign_busy", {6'd0, busy_u, done_u}, 8'b10);
        lat = 0;
        for (int k = 4; k <= 12; k++) begin
            step();
            if (done_u) begin
                lat = k;
                break;
            end
        end
        chk("busy_ign_lat", 8'(lat), 8'd8);
        chk("busy_ign_u", {5'd0, gt_u, eq_u, lt_u}, 8'b001);
        chk("busy_ign_s", {5'd0, gt_s, eq_s, lt_s}, 8'b001);
        step();

        // Back-to-back: Start is held through the Done cycle.
        a = 8'h80; b = 8'h00; start = 1'b1;
        step();                                   // E0
        step();                                   // E1
        chk("b2b_first", {3'd0, busy_u, done_u, gt_u, eq_u, lt_u}, 8'b0000_1100);
        a = 8'h00; b = 8'h80;
        step();                                   // E2
        start = 1'b0;
        chk("b2b_reload", {3'd0, busy_u, done_u, gt_u, eq_u, lt_u}, 8'b0001_0000);
        step();                                   // E3
        chk("b2b_second_u", {3'd0, busy_u, done_u, gt_u, eq_u, lt_u}, 8'b0000_1001);
        chk("b2b_second_s", {3'd0, busy_s, done_s, gt_s, eq_s, lt_s}, 8'b0000_1100);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
